// File: rtl/port_bank_pkg.sv
// Shared types and constants for the generic I/O port bank.
//   port_log_entry_t : one write-log record {port index, data byte}
//   LOG_IDX_EMPTY    : index reported by the log status register when empty
//   PORT_BANK_MAX    : largest supported NPORTS
package port_bank_pkg;

  localparam int unsigned PORT_IDX_W    = 3;
  localparam int unsigned PORT_BANK_MAX = 8;
  localparam logic [PORT_IDX_W-1:0] LOG_IDX_EMPTY = 3'b111;

  typedef struct packed {
    logic [PORT_IDX_W-1:0] idx;
    logic [7:0]            data;
  } port_log_entry_t;

endpackage

// File: rtl/sync_fifo_ovw.sv
// Synchronous FIFO that overwrites its oldest entry when pushed while full.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous flush, also clears ovf; wins over push/pop
//   push, din  : write request and data
//   pop        : read request, ignored when empty
//   dout_c     : head entry (combinational, undefined when empty)
//   empty_c    : FIFO empty (combinational)
//   count      : occupancy 0..2^LOG_DEPTH
//   ovf        : sticky, set when an entry was dropped
module sync_fifo_ovw #(
  parameter int unsigned W         = 8,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic [W-1:0]       dout_c,
  output logic               empty_c,
  output logic [LOG_DEPTH:0] count,
  output logic               ovf
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned CW    = LOG_DEPTH + 1;

  logic [W-1:0]           mem [DEPTH];
  logic [LOG_DEPTH-1:0]   wp;
  logic [LOG_DEPTH-1:0]   rp;
  logic                   full_c;
  logic                   do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty_c;
  assign dout_c  = mem[rp];

  // Storage: a push always lands at wp, even when it displaces the oldest entry.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wp] <= din;
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      // Read pointer also advances when a full push drops the oldest entry.
      if (do_pop || (push && full_c)) rp <= rp + 1'b1;
      if (push && full_c && !do_pop) ovf <= 1'b1;
      if (push && !do_pop && !full_c) count <= count + CW'(1);
      else if (do_pop && !push)       count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/port_bank.sv
// Parametrised bank of write-latched I/O port registers with per-port
// address match/mask, optional lock and read-back, and a write-log FIFO.
//   clk28, rst_n                 : clock, async active-low reset
//   bus_a/bus_d/bus_ioreq/rd/wr  : qualified CPU bus
//   unlock                       : bypass all port locks while high
//   log_en, log_clr              : log accepted writes / flush the log
//   port_q, locked               : register contents and lock state
//   log_count, log_ovf           : log occupancy and sticky overflow
//   d_out, d_out_active          : registered read data and drive enable
module port_bank
  import port_bank_pkg::*;
#(
  parameter int unsigned          NPORTS        = 4,
  parameter int unsigned          LOG_DEPTH     = 3,
  parameter logic [NPORTS*16-1:0] MATCH         = {NPORTS{16'h0000}},
  parameter logic [NPORTS*16-1:0] MASK          = {NPORTS{16'hFFFF}},
  parameter logic [NPORTS*8-1:0]  RESET_VAL     = {NPORTS{8'h00}},
  parameter logic [NPORTS-1:0]    READABLE      = {NPORTS{1'b0}},
  parameter logic [NPORTS-1:0]    LOCKABLE      = {NPORTS{1'b0}},
  parameter int unsigned          LOCK_BIT      = 5,
  parameter logic [15:0]          LOG_IDX_ADDR  = 16'hFFDF,
  parameter logic [15:0]          LOG_DATA_ADDR = 16'hFEDF
) (
  input  logic                  clk28,
  input  logic                  rst_n,
  input  logic [15:0]           bus_a,
  input  logic [7:0]            bus_d,
  input  logic                  bus_ioreq,
  input  logic                  bus_rd,
  input  logic                  bus_wr,
  input  logic                  unlock,
  input  logic                  log_en,
  input  logic                  log_clr,
  output logic [NPORTS*8-1:0]   port_q,
  output logic [NPORTS-1:0]     locked,
  output logic [LOG_DEPTH:0]    log_count,
  output logic                  log_ovf,
  output logic [7:0]            d_out,
  output logic                  d_out_active
);

  logic                  wr_cyc, rd_cyc, wr_q, rd_q, rd_log_q, wr_stb;
  logic                  log_idx_hit, log_data_hit, log_hit;
  logic                  any_hit, port_rd_ok, log_push, log_pop;
  logic [PORT_IDX_W-1:0] win;
  logic [NPORTS-1:0]     sel, accept;
  logic [7:0]            rd_port, d_out_nx;
  logic                  fifo_empty_c;
  port_log_entry_t       head_c, log_din;

  assign wr_cyc       = bus_ioreq & bus_wr;
  assign rd_cyc       = bus_ioreq & bus_rd;
  assign wr_stb       = wr_cyc & ~wr_q;
  assign log_idx_hit  = (bus_a == LOG_IDX_ADDR);
  assign log_data_hit = (bus_a == LOG_DATA_ADDR);
  assign log_hit      = log_idx_hit | log_data_hit;

  // Port decode: lowest matching index wins; log addresses shadow all ports.
  always_comb begin
    sel     = '0;
    any_hit = 1'b0;
    win     = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      if (!any_hit && (((bus_a ^ MATCH[i*16 +: 16]) & MASK[i*16 +: 16]) == 16'h0000)) begin
        any_hit = 1'b1;
        win     = PORT_IDX_W'(i);
        sel[i]  = 1'b1;
      end
    end
    if (log_hit) sel = '0;
  end

  // Per-port write acceptance and read-back mux (one-hot on sel).
  always_comb begin
    accept  = '0;
    rd_port = 8'hFF;
    for (int i = 0; i < int'(NPORTS); i++) begin
      accept[i] = wr_stb & sel[i] & (~locked[i] | unlock);
      if (sel[i] && READABLE[i]) rd_port = port_q[i*8 +: 8];
    end
  end

  assign port_rd_ok = |(sel & READABLE);
  assign log_push   = (|accept) & log_en;
  // Pop on the trailing edge of a read that addressed the log data register.
  assign log_pop    = rd_q & ~rd_cyc & rd_log_q;
  assign log_din    = '{idx: win, data: bus_d};

  // Read data selection; the log status index reads all-ones when empty.
  always_comb begin
    d_out_nx = 8'hFF;
    if (log_idx_hit)
      d_out_nx = {log_ovf, fifo_empty_c, 3'b000, (fifo_empty_c ? LOG_IDX_EMPTY : head_c.idx)};
    else if (log_data_hit)
      d_out_nx = fifo_empty_c ? 8'hFF : head_c.data;
    else if (port_rd_ok)
      d_out_nx = rd_port;
  end

  // Bus edge detection, port registers, locks and read path.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      rd_log_q     <= 1'b0;
      port_q       <= RESET_VAL;
      locked       <= '0;
      d_out        <= 8'hFF;
      d_out_active <= 1'b0;
    end else begin
      wr_q         <= wr_cyc;
      rd_q         <= rd_cyc;
      rd_log_q     <= rd_cyc & log_data_hit;
      d_out        <= rd_cyc ? d_out_nx : 8'hFF;
      d_out_active <= rd_cyc & (log_hit | port_rd_ok);
      for (int i = 0; i < int'(NPORTS); i++) begin
        if (accept[i]) begin
          port_q[i*8 +: 8] <= bus_d;
          if (LOCKABLE[i]) locked[i] <= bus_d[LOCK_BIT];
        end
      end
    end
  end

  sync_fifo_ovw #(
    .W         ($bits(port_log_entry_t)),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk28),
    .rst_n   (rst_n),
    .clr     (log_clr),
    .push    (log_push),
    .din     (log_din),
    .pop     (log_pop),
    .dout_c  (head_c),
    .empty_c (fifo_empty_c),
    .count   (log_count),
    .ovf     (log_ovf)
  );

endmodule

// File: tb/tb_port_bank.sv
// Directed bench for port_bank: two ports, lockable port 0, readable port 1,
// four-entry write log.
module tb_port_bank;

  localparam int unsigned NPORTS    = 2;
  localparam int unsigned LOG_DEPTH = 2;

  logic                  clk28 = 1'b0;
  logic                  rst_n;
  logic [15:0]           bus_a;
  logic [7:0]            bus_d;
  logic                  bus_ioreq, bus_rd, bus_wr;
  logic                  unlock, log_en, log_clr;
  logic [NPORTS*8-1:0]   port_q;
  logic [NPORTS-1:0]     locked;
  logic [LOG_DEPTH:0]    log_count;
  logic                  log_ovf;
  logic [7:0]            d_out;
  logic                  d_out_active;

  int checks = 0;
  int errors = 0;

  port_bank #(
    .NPORTS    (NPORTS),
    .LOG_DEPTH (LOG_DEPTH),
    .MATCH     ({16'h00FF, 16'h7FFD}),
    .MASK      ({16'hFFFF, 16'h8002}),
    .RESET_VAL ({8'h5A, 8'h3C}),
    .READABLE  (2'b10),
    .LOCKABLE  (2'b01)
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bus_a        (bus_a),
    .bus_d        (bus_d),
    .bus_ioreq    (bus_ioreq),
    .bus_rd       (bus_rd),
    .bus_wr       (bus_wr),
    .unlock       (unlock),
    .log_en       (log_en),
    .log_clr      (log_clr),
    .port_q       (port_q),
    .locked       (locked),
    .log_count    (log_count),
    .log_ovf      (log_ovf),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  always #18 clk28 = ~clk28;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write cycle held for 'hold' clocks; returns one negedge after release.
  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    bus_a = a; bus_d = d; bus_ioreq = 1'b1; bus_wr = 1'b1;
    repeat (hold) @(negedge clk28);
    bus_ioreq = 1'b0; bus_wr = 1'b0;
    @(negedge clk28);
  endtask

  // Read cycle; samples data/drive one clock in, and drive one clock after release.
  task automatic io_read(input logic [15:0] a, input int hold,
                         output logic [7:0] d, output logic act, output logic act_after);
    bus_a = a; bus_ioreq = 1'b1; bus_rd = 1'b1;
    @(negedge clk28);
    d = d_out; act = d_out_active;
    repeat (hold - 1) @(negedge clk28);
    bus_ioreq = 1'b0; bus_rd = 1'b0;
    @(negedge clk28);
    act_after = d_out_active;
  endtask

  initial begin
    logic [7:0] rd_d;
    logic       rd_act, rd_act_after;
    logic [7:0] exp_pop [4];

    rst_n = 1'b0; bus_a = 16'h0000; bus_d = 8'h00;
    bus_ioreq = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
    unlock = 1'b0; log_en = 1'b0; log_clr = 1'b0;
    repeat (3) @(negedge clk28);

    chk("rst_port_q",    32'(port_q), 32'h5A3C);
    chk("rst_locked",    32'(locked), 32'h0);
    chk("rst_count",     32'(log_count), 32'h0);
    chk("rst_ovf",       32'(log_ovf), 32'h0);
    chk("rst_active",    32'(d_out_active), 32'h0);
    chk("rst_d_out",     32'(d_out), 32'hFF);
    rst_n = 1'b1;
    log_en = 1'b1;
    @(negedge clk28);

    // Long write: single latch, single log entry.
    bus_a = 16'h7FFD; bus_d = 8'h15; bus_ioreq = 1'b1; bus_wr = 1'b1;
    @(negedge clk28);
    chk("wr_latency",    32'(port_q[7:0]), 32'h15);
    repeat (5) @(negedge clk28);
    chk("wr_single_log", 32'(log_count), 32'h1);
    bus_ioreq = 1'b0; bus_wr = 1'b0;
    @(negedge clk28);
    chk("wr_after_log",  32'(log_count), 32'h1);

    io_read(16'hFFDF, 2, rd_d, rd_act, rd_act_after);
    chk("log_idx_one",   32'(rd_d), 32'h00);
    chk("log_idx_drive", 32'(rd_act), 32'h1);
    chk("log_idx_nopop", 32'(log_count), 32'h1);
    io_read(16'hFEDF, 3, rd_d, rd_act, rd_act_after);
    chk("log_data_one",  32'(rd_d), 32'h15);
    chk("log_pop_count", 32'(log_count), 32'h0);

    // Lock handling on port 0.
    io_write(16'h7FFD, 8'h20, 2);
    chk("lock_set_q",    32'(port_q[7:0]), 32'h20);
    chk("lock_set",      32'(locked), 32'h1);
    chk("lock_set_log",  32'(log_count), 32'h1);
    io_write(16'h7FFD, 8'h07, 2);
    chk("locked_ignore", 32'(port_q[7:0]), 32'h20);
    chk("locked_nolog",  32'(log_count), 32'h1);
    unlock = 1'b1;
    io_write(16'h7FFD, 8'h07, 2);
    unlock = 1'b0;
    chk("unlock_q",      32'(port_q[7:0]), 32'h07);
    chk("unlock_clear",  32'(locked), 32'h0);
    chk("unlock_log",    32'(log_count), 32'h2);

    // Logging disabled: register updates, log does not.
    log_en = 1'b0;
    io_write(16'h00FF, 8'h99, 1);
    chk("nolog_q",       32'(port_q[15:8]), 32'h99);
    chk("nolog_count",   32'(log_count), 32'h2);
    log_en = 1'b1;

    // Read-back: readable port 1 drives, port 0 does not.
    io_write(16'h00FF, 8'hA5, 1);
    io_read(16'h00FF, 3, rd_d, rd_act, rd_act_after);
    chk("rd1_data",      32'(rd_d), 32'hA5);
    chk("rd1_active",    32'(rd_act), 32'h1);
    chk("rd1_release",   32'(rd_act_after), 32'h0);
    io_read(16'h7FFD, 2, rd_d, rd_act, rd_act_after);
    chk("rd0_active",    32'(rd_act), 32'h0);
    chk("rd0_d_out",     32'(rd_d), 32'hFF);

    // Flush a partially filled log.
    log_clr = 1'b1;
    @(negedge clk28);
    log_clr = 1'b0;
    chk("clr_count",     32'(log_count), 32'h0);

    // Overflow: five writes into a four-entry log drop the first.
    for (int k = 1; k <= 5; k++) io_write(16'h00FF, 8'(k), 1);
    chk("ovf_count",     32'(log_count), 32'h4);
    chk("ovf_flag",      32'(log_ovf), 32'h1);
    io_read(16'hFFDF, 1, rd_d, rd_act, rd_act_after);
    chk("ovf_idx_reg",   32'(rd_d), 32'h81);
    exp_pop = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int k = 0; k < 4; k++) begin
      io_read(16'hFEDF, 2, rd_d, rd_act, rd_act_after);
      chk($sformatf("pop_%0d", k), 32'(rd_d), 32'(exp_pop[k]));
    end
    io_read(16'hFEDF, 2, rd_d, rd_act, rd_act_after);
    chk("pop_empty_d",   32'(rd_d), 32'hFF);
    chk("pop_empty_act", 32'(rd_act), 32'h1);
    chk("pop_empty_cnt", 32'(log_count), 32'h0);
    io_read(16'hFFDF, 1, rd_d, rd_act, rd_act_after);
    chk("empty_idx_reg", 32'(rd_d), 32'hC7);

    // Flush a full, overflowed log; port registers are untouched.
    for (int k = 0; k < 5; k++) io_write(16'h00FF, 8'(8'h30 + k), 1);
    chk("full_count",    32'(log_count), 32'h4);
    log_clr = 1'b1;
    @(negedge clk28);
    log_clr = 1'b0;
    chk("clr_full_cnt",  32'(log_count), 32'h0);
    chk("clr_full_ovf",  32'(log_ovf), 32'h0);
    chk("clr_port_q",    32'(port_q), 32'h3407);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
